// File: rtl/taylor_out_collector.sv
// Capture stage for the Taylor network: queues strobed results in a FWFT FIFO and tracks frames.
// Optional macro TAYLOR_COLLECT_TAG_EN stores the channel index with each entry and exposes m_chan.
module taylor_out_collector #(
  parameter int unsigned DW    = 28,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CW    = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  io_out,
  input  logic [NCH-1:0] out_en,
  output logic [DW-1:0]  m_data,
`ifdef TAYLOR_COLLECT_TAG_EN
  output logic [CW-1:0]  m_chan,
`endif
  output logic           m_valid,
  input  logic           m_ready,
  output logic [AW:0]    count,
  output logic           frame_done,
  output logic           ovf,
  output logic           err,
  input  logic           clr_flags
);

`ifdef TAYLOR_COLLECT_TAG_EN
  localparam int unsigned EW = DW + CW;
`else
  localparam int unsigned EW = DW;
`endif

  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [NCH-1:0] mask;

  logic [CW-1:0]  chan;
  logic [EW-1:0]  entry;
  logic [EW-1:0]  head;
  logic [NCH-1:0] mask_upd;
  logic [AW:0]    count_nxt;
  logic           push_req;
  logic           multi_hot;
  logic           full;
  logic           pop;
  logic           push_ok;
  logic           frame_hit;

  // Lowest set strobe bit selects the captured channel.
  always_comb begin
    chan = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (out_en[i]) chan = CW'(i);
    end
  end

  always_comb begin
    push_req  = (out_en != '0);
    multi_hot = ((out_en & (out_en - NCH'(1))) != '0);
    full      = (count == (AW+1)'(DEPTH));
    pop       = m_valid && m_ready;
    push_ok   = push_req && (!full || pop);
    mask_upd  = mask | (NCH'(1) << chan);
    frame_hit = push_ok && (mask_upd == '1);
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + (AW+1)'(1);
    else if (!push_ok && pop) count_nxt = count - (AW+1)'(1);
  end

`ifdef TAYLOR_COLLECT_TAG_EN
  assign entry = {chan, io_out};
`else
  assign entry = io_out;
`endif

  // Storage is not reset; the cleared pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (rst && push_ok) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      m_valid    <= 1'b0;
      mask       <= '0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count      <= count_nxt;
      m_valid    <= (count_nxt != '0);
      if (push_ok) mask <= frame_hit ? '0 : mask_upd;
      frame_done <= frame_hit;
      // A set event on the same edge as clr_flags takes priority.
      if (push_req && !push_ok) ovf <= 1'b1;
      else if (clr_flags)       ovf <= 1'b0;
      if (multi_hot)            err <= 1'b1;
      else if (clr_flags)       err <= 1'b0;
    end
  end

  assign head   = mem[rd_ptr];
  assign m_data = m_valid ? head[DW-1:0] : '0;
`ifdef TAYLOR_COLLECT_TAG_EN
  assign m_chan = m_valid ? head[EW-1:DW] : '0;
`endif

endmodule

// File: tb/tb_taylor_out_collector.sv
// Self-checking bench for taylor_out_collector: directed scenarios plus random traffic vs a queue model.
module tb_taylor_out_collector;
  localparam int unsigned DW    = 28;
  localparam int unsigned NCH   = 4;
  localparam int unsigned CW    = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic           clk;
  logic           rst;
  logic [DW-1:0]  io_out;
  logic [NCH-1:0] out_en;
  logic [DW-1:0]  m_data;
`ifdef TAYLOR_COLLECT_TAG_EN
  logic [CW-1:0]  m_chan;
`endif
  logic           m_valid;
  logic           m_ready;
  logic [AW:0]    count;
  logic           frame_done;
  logic           ovf;
  logic           err;
  logic           clr_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            ch;
    logic [DW-1:0] d;
  } ent_t;

  ent_t           q[$];
  logic [NCH-1:0] seen;
  logic           exp_fd;
  logic           exp_ovf;
  logic           exp_err;

  taylor_out_collector #(.DW(DW), .NCH(NCH), .CW(CW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .io_out(io_out), .out_en(out_en), .m_data(m_data),
`ifdef TAYLOR_COLLECT_TAG_EN
    .m_chan(m_chan),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .count(count), .frame_done(frame_done),
    .ovf(ovf), .err(err), .clr_flags(clr_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour for one clock edge, from the pre-edge model state.
  task automatic model_edge(input logic r, input logic [NCH-1:0] en, input logic [DW-1:0] d,
                            input logic rdy, input logic clr);
    int   ch;
    int   ones;
    logic popped;
    logic accept;
    ent_t e;
    if (!r) begin
      q.delete();
      seen = '0; exp_fd = 0; exp_ovf = 0; exp_err = 0;
      return;
    end
    popped = (q.size() != 0) && rdy;
    accept = 0;
    exp_fd = 0;
    ch = -1;
    ones = 0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (en[i]) begin
        ones++;
        if (ch < 0) ch = i;
      end
    end
    if (clr) begin exp_ovf = 0; exp_err = 0; end
    if (ones > 1) exp_err = 1;
    if (ones > 0) begin
      if (q.size() < int'(DEPTH) || popped) accept = 1;
      else exp_ovf = 1;
    end
    if (popped) void'(q.pop_front());
    if (accept) begin
      e.ch = ch; e.d = d;
      q.push_back(e);
      seen[ch] = 1'b1;
      if (seen == '1) begin seen = '0; exp_fd = 1; end
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic tick(input logic r, input logic [NCH-1:0] en, input logic [DW-1:0] d,
                      input logic rdy, input logic clr);
    rst = r; out_en = en; io_out = d; m_ready = rdy; clr_flags = clr;
    model_edge(r, en, d, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b0);
    tick(1'b1, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || count !== '0 || frame_done !== 1'b0 ||
        ovf !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h count=%0d fd=%b ovf=%b err=%b, need all 0",
               m_valid, m_data, count, frame_done, ovf, err);
    end
`ifdef TAYLOR_COLLECT_TAG_EN
    checks++;
    if (m_chan !== '0) begin errors++; $display("FAIL reset_chan: got %0d need 0", m_chan); end
`endif
  endtask

  task automatic test_single_capture();
    do_reset(2);
    tick(1'b1, 4'b0100, 28'h0000123, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 28'h0000123 || count !== 4'd1) begin
      errors++;
      $display("FAIL single_capture: valid=%b data=%h count=%0d, need 1 0000123 1", m_valid, m_data, count);
    end
`ifdef TAYLOR_COLLECT_TAG_EN
    checks++;
    if (m_chan !== 2'd2) begin errors++; $display("FAIL single_chan: got %0d need 2", m_chan); end
`endif
    tick(1'b1, '0, '0, 1'b1, 1'b0);
    checks++;
    if (m_valid !== 1'b0 || count !== 4'd0 || m_data !== '0) begin
      errors++;
      $display("FAIL single_pop: valid=%b count=%0d data=%h, need 0 0 0", m_valid, count, m_data);
    end
  endtask

  task automatic test_frame();
    int            chs [5] = '{0, 1, 1, 3, 2};
    logic [DW-1:0] vals[5];
    int            pulses = 0;
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      vals[i] = DW'($urandom);
      tick(1'b1, NCH'(1) << chs[i], vals[i], 1'b1, 1'b0);
      if (frame_done) pulses++;
      checks++;
      if (frame_done !== (i == 4) || m_valid !== 1'b1 || m_data !== vals[i]) begin
        errors++;
        $display("FAIL frame_step%0d: fd=%b valid=%b data=%h, need fd=%b valid=1 data=%h",
                 i, frame_done, m_valid, m_data, (i == 4), vals[i]);
      end
`ifdef TAYLOR_COLLECT_TAG_EN
      checks++;
      if (m_chan !== CW'(chs[i])) begin
        errors++; $display("FAIL frame_tag%0d: got %0d need %0d", i, m_chan, chs[i]);
      end
`endif
    end
    tick(1'b1, '0, '0, 1'b1, 1'b0);
    if (frame_done) pulses++;
    checks++;
    if (pulses != 1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_pulses: pulses=%0d valid=%b, need 1 pulse and valid 0", pulses, m_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset(1);
    for (int i = 1; i <= 9; i++) begin
      tick(1'b1, 4'b0001, DW'(i), 1'b0, 1'b0);
      if (i == 8) begin
        checks++;
        if (count !== 4'd8 || ovf !== 1'b0) begin
          errors++; $display("FAIL ovf_fill8: count=%0d ovf=%b, need 8 0", count, ovf);
        end
      end
    end
    checks++;
    if (count !== 4'd8 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_ninth: count=%0d ovf=%b, need 8 1", count, ovf);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== DW'(i)) begin
        errors++; $display("FAIL ovf_drain%0d: valid=%b data=%h, need 1 %h", i, m_valid, m_data, DW'(i));
      end
      tick(1'b1, '0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (m_valid !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL ovf_empty: valid=%b count=%0d, need 0 0", m_valid, count);
    end
    tick(1'b1, '0, '0, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b need 0", ovf); end
  endtask

  task automatic test_full_pop();
    do_reset(1);
    for (int i = 0; i < 8; i++) tick(1'b1, 4'b0010, DW'(16 + i), 1'b0, 1'b0);
    tick(1'b1, 4'b1000, 28'hFFFFFFF, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd8 || ovf !== 1'b0) begin
      errors++; $display("FAIL full_pop: count=%0d ovf=%b, need 8 0", count, ovf);
    end
    for (int i = 1; i < 8; i++) tick(1'b1, '0, '0, 1'b1, 1'b0);
    checks++;
    if (m_data !== 28'hFFFFFFF || count !== 4'd1) begin
      errors++; $display("FAIL full_pop_last: data=%h count=%0d, need fffffff 1", m_data, count);
    end
  endtask

  task automatic test_multi_hot();
    do_reset(1);
    tick(1'b1, 4'b1010, DW'(-5), 1'b0, 1'b0);
    checks++;
    if (m_data !== DW'(-5) || err !== 1'b1 || m_valid !== 1'b1) begin
      errors++; $display("FAIL multi_hot: data=%h err=%b valid=%b, need %h 1 1", m_data, err, m_valid, DW'(-5));
    end
`ifdef TAYLOR_COLLECT_TAG_EN
    checks++;
    if (m_chan !== 2'd1) begin errors++; $display("FAIL multi_hot_tag: got %0d need 1", m_chan); end
`endif
    tick(1'b1, 4'b0001, DW'(1), 1'b1, 1'b0);
    tick(1'b1, 4'b0100, DW'(2), 1'b1, 1'b0);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL multi_hot_mask: frame_done=%b after ch0,1,2, need 0", frame_done);
    end
    tick(1'b1, 4'b1000, DW'(3), 1'b1, 1'b0);
    checks++;
    if (frame_done !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL multi_hot_frame: fd=%b err=%b, need 1 1", frame_done, err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fd_seen = 0;
    do_reset(1);
    tick(1'b1, 4'b0001, DW'(7), 1'b0, 1'b0);
    tick(1'b1, 4'b0010, DW'(8), 1'b0, 1'b0);
    tick(1'b0, 4'b0100, DW'(9), 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL mid_reset: valid=%b count=%0d, need 0 0", m_valid, count);
    end
    tick(1'b1, 4'b0100, DW'(10), 1'b0, 1'b0);
    if (frame_done) fd_seen++;
    tick(1'b1, 4'b1000, DW'(11), 1'b0, 1'b0);
    if (frame_done) fd_seen++;
    checks++;
    if (fd_seen != 0 || count !== 4'd2 || m_data !== DW'(10)) begin
      errors++; $display("FAIL mid_frame: fd_seen=%0d count=%0d data=%h, need 0 2 %h", fd_seen, count, m_data, DW'(10));
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] en;
    logic [DW-1:0]  exp_data;
    int             sel;
    do_reset(1);
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 45)      en = '0;
      else if (sel < 88) en = NCH'(1) << $urandom_range(0, NCH - 1);
      else               en = NCH'($urandom);
      tick(($urandom_range(0, 99) >= 2), en, DW'($urandom),
           ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 5));
      exp_data = (q.size() != 0) ? q[0].d : '0;
      checks++;
      if (m_valid !== (q.size() != 0) || m_data !== exp_data || count !== (AW+1)'(q.size()) ||
          frame_done !== exp_fd || ovf !== exp_ovf || err !== exp_err) begin
        errors++;
        $display("FAIL random%0d: valid=%b data=%h count=%0d fd=%b ovf=%b err=%b, need %b %h %0d %b %b %b",
                 n, m_valid, m_data, count, frame_done, ovf, err,
                 (q.size() != 0), exp_data, q.size(), exp_fd, exp_ovf, exp_err);
      end
`ifdef TAYLOR_COLLECT_TAG_EN
      checks++;
      if (m_chan !== ((q.size() != 0) ? CW'(q[0].ch) : CW'(0))) begin
        errors++; $display("FAIL random_tag%0d: got %0d", n, m_chan);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b0; out_en = '0; io_out = '0; m_ready = 1'b0; clr_flags = 1'b0;
    seen = '0; exp_fd = 0; exp_ovf = 0; exp_err = 0;
    test_reset();
    test_single_capture();
    test_frame();
    test_overflow();
    test_full_pop();
    test_multi_hot();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
